// File: rtl/fifo_pkg.sv
// Shared definitions for the multi-lane shift-register FIFO: width helpers and
// bit positions inside the sticky error vector.
package fifo_pkg;

    localparam int ERR_OVERFLOW  = 0;
    localparam int ERR_UNDERFLOW = 1;
    localparam int ERR_BAD_TAG   = 2;

    // A single lane still needs one tag bit so din keeps a well-formed layout.
    function automatic int tag_width(input int flux);
        return (flux <= 1) ? 1 : $clog2(flux);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_sr_lane.sv
// One flux lane: a shift-register FIFO with its head word always in slot 0,
// so the head is visible on dout without any read latency.
module fifo_sr_lane
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr,
    input  logic [DATA_WIDTH-1:0]         data,
    input  logic                          rd,
    input  logic                          flush,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  pop;
    logic                  push;
    logic                  shift;
    logic [CNT_W-1:0]      wr_idx;
    logic [CNT_W-1:0]      count_next;

    assign full        = (count == DEPTH_C);
    assign empty       = (count == '0);
    assign almost_full = (count >= AF_C);
    assign dout        = mem[0];

    // A full lane only takes a write when the same edge frees a slot.
    assign pop    = rd && !empty && !flush;
    assign push   = wr && !flush && (!full || pop);
    // Popping the last word leaves slot 0 alone so dout holds its last value.
    assign shift  = pop && (count > CNT_W'(1));
    assign wr_idx = pop ? (count - CNT_W'(1)) : count;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            for (int j = 0; j < DEPTH - 1; j++) begin
                if (shift) mem[j] <= mem[j+1];
            end
            for (int j = 0; j < DEPTH; j++) begin
                if (push && (CNT_W'(j) == wr_idx)) mem[j] <= data;
            end
            count <= count_next;
        end
    end

endmodule

// File: rtl/fifo_sr_mf.sv
// Multi-flux FIFO: routes each write to the lane named by its tag and keeps
// sticky error flags for bad tags, underflows and overflows.
module fifo_sr_mf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int FLUX       = 2,
    parameter int AF_LEVEL   = DEPTH - 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [DATA_WIDTH+tag_width(FLUX)-1:0] din,
    input  logic                                  write,
    output logic [FLUX-1:0]                       full,
    output logic [FLUX-1:0]                       almost_full,
    output logic [FLUX*DATA_WIDTH-1:0]            dout,
    input  logic [FLUX-1:0]                       read,
    output logic [FLUX-1:0]                       empty,
    output logic [FLUX*cnt_width(DEPTH)-1:0]      count,
    input  logic [FLUX-1:0]                       flush,
    output logic [2:0]                            err
);

    localparam int TAG_W = tag_width(FLUX);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam logic [TAG_W:0] FLUX_L = (TAG_W + 1)'(FLUX);

    logic [TAG_W-1:0] tag;
    logic             tag_ok;
    logic             bad_tag;
    logic [FLUX-1:0]  lane_wr;
    logic [FLUX-1:0]  underflow;
    logic [FLUX-1:0]  overflow;

    assign tag     = din[DATA_WIDTH +: TAG_W];
    assign tag_ok  = ({1'b0, tag} < FLUX_L);
    assign bad_tag = write && !tag_ok;

    for (genvar i = 0; i < FLUX; i++) begin : g_lane
        assign lane_wr[i] = write && tag_ok && (tag == TAG_W'(i));
        // A flushed lane swallows its write/read silently, so flush masks both errors.
        assign underflow[i] = read[i] && empty[i] && !flush[i];
        assign overflow[i]  = lane_wr[i] && full[i] && !read[i] && !flush[i];

        fifo_sr_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .AF_LEVEL   (AF_LEVEL)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .wr          (lane_wr[i]),
            .data        (din[DATA_WIDTH-1:0]),
            .rd          (read[i]),
            .flush       (flush[i]),
            .dout        (dout[i*DATA_WIDTH +: DATA_WIDTH]),
            .count       (count[i*CNT_W +: CNT_W]),
            .full        (full[i]),
            .empty       (empty[i]),
            .almost_full (almost_full[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= '0;
        end else begin
            err[ERR_BAD_TAG]   <= err[ERR_BAD_TAG]   | bad_tag;
            err[ERR_UNDERFLOW] <= err[ERR_UNDERFLOW] | (|underflow);
            err[ERR_OVERFLOW]  <= err[ERR_OVERFLOW]  | (|overflow);
        end
    end

endmodule

// File: tb/tb_fifo_sr_mf.sv
// Bench for fifo_sr_mf (3 lanes, depth 8): directed vectors and sequences,
// then random traffic compared against a queue-based reference model.
module tb_fifo_sr_mf;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int FLUX  = 3;
    localparam int CW    = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [DW+1:0]   din = '0;
    logic            write = 1'b0;
    logic [FLUX-1:0] full, almost_full, empty;
    logic [FLUX-1:0] read = '0;
    logic [FLUX-1:0] flush = '0;
    logic [FLUX*DW-1:0] dout;
    logic [FLUX*CW-1:0] count;
    logic [2:0]      err;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mq [FLUX][$];
    logic [DW-1:0] mLast [FLUX];
    logic [2:0]    mErr;

    fifo_sr_mf #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FLUX(FLUX)) dut (
        .clk(clk), .rst(rst), .din(din), .write(write), .full(full),
        .almost_full(almost_full), .dout(dout), .read(read), .empty(empty),
        .count(count), .flush(flush), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [DW+1:0] mk(input int t, input logic [DW-1:0] d);
        return {2'(t), d};
    endfunction

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < FLUX; i++) begin
            mq[i].delete();
            mLast[i] = '0;
        end
        mErr = '0;
    endtask

    // Reference behaviour: plain queues, one per lane, updated per clock edge.
    task automatic modelStep(input logic w, input logic [DW+1:0] d,
                             input logic [FLUX-1:0] rd, input logic [FLUX-1:0] fl);
        int  t;
        bit  bad;
        bit  pop;
        bit  push;
        t   = int'(d[DW+1:DW]);
        bad = w && (t >= FLUX);
        if (bad) mErr[2] = 1'b1;
        for (int i = 0; i < FLUX; i++) begin
            if (fl[i]) begin
                mq[i].delete();
                continue;
            end
            pop = rd[i] && (mq[i].size() > 0);
            if (rd[i] && mq[i].size() == 0) mErr[1] = 1'b1;
            push = w && !bad && (t == i);
            if (push && mq[i].size() == DEPTH && !pop) begin
                mErr[0] = 1'b1;
                push = 1'b0;
            end
            if (pop) void'(mq[i].pop_front());
            if (push) mq[i].push_back(d[DW-1:0]);
            if (mq[i].size() > 0) mLast[i] = mq[i][0];
        end
    endtask

    task automatic checkOutput(input string tag);
        for (int i = 0; i < FLUX; i++) begin
            checkVal($sformatf("%s count[%0d]", tag, i), 64'(count[i*CW +: CW]), 64'(mq[i].size()));
            checkVal($sformatf("%s empty[%0d]", tag, i), 64'(empty[i]), 64'(mq[i].size() == 0));
            checkVal($sformatf("%s full[%0d]", tag, i), 64'(full[i]), 64'(mq[i].size() == DEPTH));
            checkVal($sformatf("%s almost_full[%0d]", tag, i), 64'(almost_full[i]), 64'(mq[i].size() >= DEPTH - 1));
            checkVal($sformatf("%s dout[%0d]", tag, i), 64'(dout[i*DW +: DW]), 64'(mLast[i]));
        end
        checkVal($sformatf("%s err", tag), 64'(err), 64'(mErr));
    endtask

    task automatic applyStimulus(input logic w, input logic [DW+1:0] d,
                                 input logic [FLUX-1:0] rd, input logic [FLUX-1:0] fl);
        write = w;
        din   = d;
        read  = rd;
        flush = fl;
        modelStep(w, d, rd, fl);
        @(posedge clk);
        #1;
        write = 1'b0;
        din   = '0;
        read  = '0;
        flush = '0;
    endtask

    task automatic doReset();
        write = 1'b0;
        read  = '0;
        flush = '0;
        din   = '0;
        rst   = 1'b0;
        modelReset();
        #2;
        checkOutput("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          wr;
        logic [DW+1:0] d;
        logic [2:0]    rd;
        logic [3:0]    c0;
        logic [DW-1:0] h0;
        logic          e0;
        logic [3:0]    c1;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{1'b1, mk(0, 32'hA), 3'b000, 4'd1, 32'hA, 1'b0, 4'd0};
        vecs[1] = '{1'b1, mk(0, 32'hB), 3'b000, 4'd2, 32'hA, 1'b0, 4'd0};
        vecs[2] = '{1'b0, mk(0, 32'h0), 3'b001, 4'd1, 32'hB, 1'b0, 4'd0};
        vecs[3] = '{1'b0, mk(0, 32'h0), 3'b001, 4'd0, 32'hB, 1'b1, 4'd0};

        // Reset values and basic FWFT ordering on lane 0.
        doReset();
        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].wr, vecs[v].d, vecs[v].rd, 3'b000);
            checkVal($sformatf("vec%0d count[0]", v), 64'(count[3:0]), 64'(vecs[v].c0));
            checkVal($sformatf("vec%0d dout[0]", v), 64'(dout[31:0]), 64'(vecs[v].h0));
            checkVal($sformatf("vec%0d empty[0]", v), 64'(empty[0]), 64'(vecs[v].e0));
            checkVal($sformatf("vec%0d count[1]", v), 64'(count[7:4]), 64'(vecs[v].c1));
            checkOutput($sformatf("vec%0d", v));
        end

        // Fill lane 1, overflow drop, then write-with-read on a full lane.
        doReset();
        for (int k = 0; k < 7; k++) applyStimulus(1'b1, mk(1, 32'h100 + k), 3'b000, 3'b000);
        checkVal("fill7 count[1]", 64'(count[7:4]), 64'd7);
        checkVal("fill7 almost_full[1]", 64'(almost_full[1]), 64'd1);
        checkVal("fill7 full[1]", 64'(full[1]), 64'd0);
        applyStimulus(1'b1, mk(1, 32'h107), 3'b000, 3'b000);
        checkVal("fill8 full[1]", 64'(full[1]), 64'd1);
        applyStimulus(1'b1, mk(1, 32'h1FF), 3'b000, 3'b000);
        checkVal("ovf count[1]", 64'(count[7:4]), 64'd8);
        checkVal("ovf err", 64'(err), 64'b001);
        applyStimulus(1'b1, mk(1, 32'h108), 3'b010, 3'b000);
        checkVal("full rw count[1]", 64'(count[7:4]), 64'd8);
        checkVal("full rw dout[1]", 64'(dout[63:32]), 64'h101);
        checkOutput("fill");

        // Bad tag.
        doReset();
        applyStimulus(1'b1, mk(3, 32'hDEAD), 3'b000, 3'b000);
        checkVal("badtag err", 64'(err), 64'b100);
        checkVal("badtag count", 64'(count), 64'd0);

        // Underflow read with simultaneous write.
        doReset();
        applyStimulus(1'b1, mk(0, 32'h5), 3'b001, 3'b000);
        checkVal("uflow err", 64'(err), 64'b010);
        checkVal("uflow dout[0]", 64'(dout[31:0]), 64'h5);
        checkVal("uflow count[0]", 64'(count[3:0]), 64'd1);

        // Flush with same-cycle write, then async reset with data in flight.
        doReset();
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, mk(0, 32'h40 + k), 3'b000, 3'b000);
        applyStimulus(1'b1, mk(0, 32'h99), 3'b001, 3'b001);
        checkVal("flush count[0]", 64'(count[3:0]), 64'd0);
        checkVal("flush err", 64'(err), 64'd0);
        applyStimulus(1'b1, mk(1, 32'h11), 3'b000, 3'b000);
        applyStimulus(1'b1, mk(2, 32'h22), 3'b000, 3'b000);
        applyStimulus(1'b1, mk(3, 32'h33), 3'b000, 3'b000);
        rst = 1'b0;
        modelReset();
        #2;
        checkVal("async rst count", 64'(count), 64'd0);
        checkVal("async rst empty", 64'(empty), 64'b111);
        checkVal("async rst err", 64'(err), 64'd0);
        checkVal("async rst dout", 64'(dout), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, mk(0, 32'h77), 3'b000, 3'b000);
        checkVal("post rst dout[0]", 64'(dout[31:0]), 64'h77);
        checkOutput("post rst");

        // Random traffic against the queue model.
        doReset();
        for (int n = 0; n < 800; n++) begin
            logic [FLUX-1:0] rd;
            logic [FLUX-1:0] fl;
            for (int i = 0; i < FLUX; i++) begin
                rd[i] = ($urandom_range(0, 9) < 3);
                fl[i] = ($urandom_range(0, 39) == 0);
            end
            applyStimulus(($urandom_range(0, 9) < 7), mk($urandom_range(0, 3), $urandom), rd, fl);
            checkOutput($sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
